homa_tx_msg_prio_reg: RTL and testbench
=======================================

// Module: homa_tx_msg_prio_reg
// PURPOSE
// Responder side of the txMsgPrioReg extern that the Homa egress pipeline issues requests to.
// Holds one priority byte per TX message ID in a synchronous RAM. Serves pipeline read/update
// requests with a fixed 2-cycle latency and read-before-write semantics. Also accepts
// asynchronous priority writes from the TX message scheduler (control port).
// Sits between the egress SDNet wrapper and the NIC TX message-state logic.
// PARAMETERS
// NUM_ENTRIES   1024  number of message slots; power of 2, >=4
// IDX_W         16    width of the index fields on the request and control ports
// PRIO_W        8     width of a priority entry
// DEFAULT_PRIO  0     value written to every entry at init; returned for out-of-range indices
// PORTS
// clock               in   1       single clock
// reset               in   1       asynchronous, active-high
// req_valid           in   1       pipeline request strobe; no backpressure, one request per cycle max
// req_bits_index      in   IDX_W   message ID
// req_bits_update     in   1       1: write req_bits_prio after the read
// req_bits_prio       in   PRIO_W  new priority (used only when update=1)
// resp_valid          out  1       response strobe, exactly 2 cycles after req_valid
// resp_bits_prio      out  PRIO_W  entry value before this request
// ctrl_wr_valid       in   1       scheduler write strobe
// ctrl_wr_index       in   IDX_W   message ID to write
// ctrl_wr_prio        in   PRIO_W  value to write
// init_done           out  1       1 once the array is cleared
// oob_err             out  1       1-cycle pulse, aligned with resp_valid, for an out-of-range req index
// BEHAVIOUR
// - Reset values: resp_valid=0, resp_bits_prio=0, init_done=0, oob_err=0. FSM=INIT, init_addr=0.
//   Pipeline valid bits are cleared.
// - FSM INIT: writes DEFAULT_PRIO to RAM[init_addr] each cycle and increments init_addr.
//   At init_addr==NUM_ENTRIES-1 the last write is performed; next state is RUN and init_done=1.
//   INIT lasts exactly NUM_ENTRIES cycles.
// - FSM RUN: stays in RUN until reset. There is no other exit.
// - Requests during INIT: resp_valid is still asserted 2 cycles later, with resp_bits_prio=DEFAULT_PRIO.
//   Update writes and control writes issued during INIT are dropped.
// - Latency: request accepted in cycle t -> RAM read in t, read data in t+1, registered resp in t+2.
//   A request every cycle gives a response every cycle, in order.
// - Response value: the entry as left by all earlier-cycle control writes and request updates,
//   including writes made in t-1 and t-2. A forwarding path covers the RAM read latency.
//   The RAM must never return stale data.
// - Same-cycle ordering: a control write and a request in the same cycle are ordered
//   control write first, then request.
//   Same index: the response returns ctrl_wr_prio; the final entry is req_bits_prio if update=1,
//   otherwise ctrl_wr_prio.
// - Write port: one RAM write port. When both a control write and a request update are
//   active in the same cycle, only the winning write is committed.
//   Same index -> the request's value is committed.
//   Different indices -> the control write is held in a 1-deep pending register and committed next cycle.
//   Pending entries take part in forwarding.
//   If a new control write collides again while one is pending, the pending write commits first
//   and the request update is deferred instead. Every write must land; none may be lost.
// - Range check: an index is out of range when index >= NUM_ENTRIES. Only the low log2(NUM_ENTRIES)
//   bits address the RAM.
//   Out-of-range request: resp=DEFAULT_PRIO, oob_err=1 with resp_valid, update dropped.
//   Out-of-range control write: dropped silently.
// - Arithmetic: no arithmetic on priority values; they are stored verbatim. init_addr wraps are impossible.
// - Reset mid-operation: in-flight responses are discarded (resp_valid=0 from reset onward),
//   any pending write is discarded, and the array is re-cleared via INIT.
// TESTING
// 1. Reset, idle 1024 cycles -> init_done rises exactly at cycle 1024.
//    Reads of idx 0, 511 and 1023 all return 0.
// 2. RUN: req{idx=5,upd=1,prio=7} at t, req{idx=5,upd=0} at t+1 -> resp at t+2 = 0, resp at t+3 = 7.
// 3. Same cycle: ctrl{idx=9,prio=3} + req{idx=9,upd=1,prio=6} -> resp=3; a later read of idx 9 = 6.
// 4. Same cycle: ctrl{idx=2,prio=4} + req{idx=8,upd=1,prio=1} -> reads 1 and 2 cycles later
//    return idx2=4 and idx8=1. No write is lost.
// 5. req{idx=1024,upd=1,prio=9} -> resp=0 with oob_err=1; a later read of idx 0 returns its prior value.
// 6. Issue 3 back-to-back requests, assert reset at the 2nd response -> no further resp_valid,
//    init_done=0, and a full INIT is rerun.

Source files
------------

// File: rtl/homa_tx_msg_prio_reg.sv
// -----------------------------------------------------------------------------
// homa_tx_msg_prio_reg
//
// Responder for the txMsgPrioReg extern used by the Homa egress pipeline.
// It holds one priority value per TX message ID in a single-port-write
// synchronous RAM. It serves two kinds of traffic:
//   * pipeline requests: read the stored priority, and optionally replace it
//     (read-before-write). Each request gets exactly one response two cycles
//     later. There is no backpressure.
//   * scheduler control writes: unsolicited priority updates.
// After reset the whole array is cleared to DEFAULT_PRIO, one entry per cycle.
//
// Ports
//   clock, reset         single clock, asynchronous active-high reset
//   req_valid            pipeline request strobe (max one per cycle)
//   req_bits_index       message ID of the request
//   req_bits_update      1: store req_bits_prio after reading
//   req_bits_prio        new priority for an update request
//   resp_valid           response strobe, two cycles after req_valid
//   resp_bits_prio       entry value as seen just before the request
//   ctrl_wr_valid        scheduler write strobe
//   ctrl_wr_index        message ID of the scheduler write
//   ctrl_wr_prio         value of the scheduler write
//   init_done            high once the array has been cleared
//   oob_err              pulse with resp_valid when the request index was
//                        out of range
// -----------------------------------------------------------------------------
module homa_tx_msg_prio_reg #(
  parameter int                NUM_ENTRIES  = 1024,
  parameter int                IDX_W        = 16,
  parameter int                PRIO_W       = 8,
  parameter logic [PRIO_W-1:0] DEFAULT_PRIO = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_bits_index,
  input  logic              req_bits_update,
  input  logic [PRIO_W-1:0] req_bits_prio,
  output logic              resp_valid,
  output logic [PRIO_W-1:0] resp_bits_prio,
  input  logic              ctrl_wr_valid,
  input  logic [IDX_W-1:0]  ctrl_wr_index,
  input  logic [PRIO_W-1:0] ctrl_wr_prio,
  output logic              init_done,
  output logic              oob_err
);

  localparam int AW = $clog2(NUM_ENTRIES);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One logical write waiting for (or competing for) the RAM write port.
  typedef struct packed {
    logic              v;
    logic [AW-1:0]     idx;
    logic [PRIO_W-1:0] val;
  } wr_t;

  function automatic logic idx_oob(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} >= (IDX_W+1)'(NUM_ENTRIES));
  endfunction

  // ---------------------------------------------------------------------------
  // State declarations
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [AW-1:0]     init_addr_q, init_addr_d;
  logic              init_wr;
  logic              run;

  wr_t               slot_q [2];
  wr_t               slot_d [2];
  wr_t               items  [4];
  logic              commit_v;
  logic [1:0]        sel;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [PRIO_W-1:0] wr_data;

  logic              req_oob, ctrl_oob;
  logic [AW-1:0]     req_addr, ctrl_addr;
  logic              c_v, r_v;

  logic              fwd_hit_p0;
  logic [PRIO_W-1:0] fwd_val_p0;

  logic              vld_p1_q, vld_p1_d;
  logic              oob_p1_q, oob_p1_d;
  logic              dflt_p1_q, dflt_p1_d;
  logic              fwd_hit_p1_q, fwd_hit_p1_d;
  logic [PRIO_W-1:0] fwd_val_p1_q;
  logic [PRIO_W-1:0] ram_rd_p1;

  logic              resp_valid_q, resp_valid_d;
  logic [PRIO_W-1:0] resp_prio_q, resp_prio_d;
  logic              oob_err_q, oob_err_d;

  logic [PRIO_W-1:0] mem [NUM_ENTRIES];

  // ---------------------------------------------------------------------------
  // Init / run FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    init_wr     = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_wr = 1'b1;
        // The last entry is written in this cycle; init_addr stops here so
        // it never wraps.
        if (init_addr_q == AW'(NUM_ENTRIES - 1)) begin
          state_d = ST_RUN;
        end else begin
          init_addr_d = init_addr_q + AW'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  // ---------------------------------------------------------------------------
  // Stage p0: range checks, write arbitration, forwarding, RAM read issue
  // ---------------------------------------------------------------------------
  assign req_oob   = idx_oob(req_bits_index);
  assign ctrl_oob  = idx_oob(ctrl_wr_index);
  assign req_addr  = req_bits_index[AW-1:0];
  assign ctrl_addr = ctrl_wr_index[AW-1:0];

  // Writes arriving during INIT or aimed outside the array are dropped.
  assign c_v = run & ctrl_wr_valid & ~ctrl_oob;
  assign r_v = run & req_valid & req_bits_update & ~req_oob;

  // Gather every logical write of this cycle in program order: pending
  // slots, then the control write, then the request update. A later write
  // to an index already in the list overwrites it in place, so the list
  // never holds the same index twice.
  always_comb begin
    items[0] = slot_q[0];
    items[1] = slot_q[1];
    items[2] = '0;
    items[3] = '0;
    if (c_v) begin
      if (items[0].v && items[0].idx == ctrl_addr) begin
        items[0].val = ctrl_wr_prio;
      end else if (items[1].v && items[1].idx == ctrl_addr) begin
        items[1].val = ctrl_wr_prio;
      end else begin
        items[2] = {1'b1, ctrl_addr, ctrl_wr_prio};
      end
    end
    if (r_v) begin
      if (items[0].v && items[0].idx == req_addr) begin
        items[0].val = req_bits_prio;
      end else if (items[1].v && items[1].idx == req_addr) begin
        items[1].val = req_bits_prio;
      end else if (items[2].v && items[2].idx == req_addr) begin
        items[2].val = req_bits_prio;
      end else begin
        items[3] = {1'b1, req_addr, req_bits_prio};
      end
    end
  end

  // Pending writes drain first; with nothing pending the request update
  // wins the port and a colliding control write waits a cycle.
  always_comb begin
    commit_v = 1'b1;
    sel      = 2'd0;
    if (items[0].v) begin
      sel = 2'd0;
    end else if (items[1].v) begin
      sel = 2'd1;
    end else if (items[3].v) begin
      sel = 2'd3;
    end else if (items[2].v) begin
      sel = 2'd2;
    end else begin
      commit_v = 1'b0;
    end
  end

  // Everything not committed this cycle moves into the pending slots,
  // oldest first. Two slots cover a control write colliding with request
  // updates in two consecutive cycles; the scheduler is expected to leave
  // at least one collision-free cycle after that so the slots can drain.
  always_comb begin : slot_fill
    int n;
    n         = 0;
    slot_d[0] = '0;
    slot_d[1] = '0;
    for (int i = 0; i < 4; i++) begin
      if (items[i].v && !(commit_v && sel == 2'(i))) begin
        if (n == 0) begin
          slot_d[0] = items[i];
        end else if (n == 1) begin
          slot_d[1] = items[i];
        end
        n = n + 1;
      end
    end
  end

  always_comb begin
    wr_en   = init_wr | commit_v;
    wr_addr = items[sel].idx;
    wr_data = items[sel].val;
    if (init_wr) begin
      wr_addr = init_addr_q;
      wr_data = DEFAULT_PRIO;
    end
  end

  // The RAM read issued now only reflects writes committed in earlier
  // cycles. Anything still sitting in a pending slot, plus a same-cycle
  // control write (ordered before the request), is overlaid here. Slots
  // hold distinct indices, and the control write is the newest.
  always_comb begin
    fwd_hit_p0 = 1'b0;
    fwd_val_p0 = DEFAULT_PRIO;
    if (slot_q[0].v && slot_q[0].idx == req_addr) begin
      fwd_hit_p0 = 1'b1;
      fwd_val_p0 = slot_q[0].val;
    end
    if (slot_q[1].v && slot_q[1].idx == req_addr) begin
      fwd_hit_p0 = 1'b1;
      fwd_val_p0 = slot_q[1].val;
    end
    if (c_v && ctrl_addr == req_addr) begin
      fwd_hit_p0 = 1'b1;
      fwd_val_p0 = ctrl_wr_prio;
    end
  end

  assign vld_p1_d     = req_valid;
  assign oob_p1_d     = req_oob;
  assign dflt_p1_d    = req_oob | ~run;
  assign fwd_hit_p1_d = fwd_hit_p0;

  // Read-before-write RAM: a write and a read to the same address in one
  // cycle return the old contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    ram_rd_p1    <= mem[req_addr];
    fwd_val_p1_q <= fwd_val_p0;
  end

  // ---------------------------------------------------------------------------
  // Stage p1: select forwarded or RAM data into the response register
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_valid_d = vld_p1_q;
    oob_err_d    = vld_p1_q & oob_p1_q;
    resp_prio_d  = resp_prio_q;
    if (vld_p1_q) begin
      if (dflt_p1_q) begin
        resp_prio_d = DEFAULT_PRIO;
      end else if (fwd_hit_p1_q) begin
        resp_prio_d = fwd_val_p1_q;
      end else begin
        resp_prio_d = ram_rd_p1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: registered response
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      slot_q[0]    <= '0;
      slot_q[1]    <= '0;
      vld_p1_q     <= 1'b0;
      oob_p1_q     <= 1'b0;
      dflt_p1_q    <= 1'b0;
      fwd_hit_p1_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_prio_q  <= '0;
      oob_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      slot_q[0]    <= slot_d[0];
      slot_q[1]    <= slot_d[1];
      vld_p1_q     <= vld_p1_d;
      oob_p1_q     <= oob_p1_d;
      dflt_p1_q    <= dflt_p1_d;
      fwd_hit_p1_q <= fwd_hit_p1_d;
      resp_valid_q <= resp_valid_d;
      resp_prio_q  <= resp_prio_d;
      oob_err_q    <= oob_err_d;
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_bits_prio = resp_prio_q;
  assign oob_err        = oob_err_q;

endmodule

// File: tb/tb_homa_tx_msg_prio_reg.sv
module tb_homa_tx_msg_prio_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_bits_index;
  logic        req_bits_update;
  logic [7:0]  req_bits_prio;
  logic        resp_valid;
  logic [7:0]  resp_bits_prio;
  logic        ctrl_wr_valid;
  logic [15:0] ctrl_wr_index;
  logic [7:0]  ctrl_wr_prio;
  logic        init_done;
  logic        oob_err;

  always #5 clock = ~clock;

  homa_tx_msg_prio_reg #(
    .NUM_ENTRIES (1024),
    .IDX_W       (16),
    .PRIO_W      (8),
    .DEFAULT_PRIO(8'h00)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_bits_index (req_bits_index),
    .req_bits_update(req_bits_update),
    .req_bits_prio  (req_bits_prio),
    .resp_valid     (resp_valid),
    .resp_bits_prio (resp_bits_prio),
    .ctrl_wr_valid  (ctrl_wr_valid),
    .ctrl_wr_index  (ctrl_wr_index),
    .ctrl_wr_prio   (ctrl_wr_prio),
    .init_done      (init_done),
    .oob_err        (oob_err)
  );

  typedef struct {
    logic [7:0] prio;
    logic       oob;
    int         tag;
  } exp_t;

  typedef struct {
    logic        cv;
    logic [15:0] cidx;
    logic [7:0]  cprio;
    logic        rv;
    logic [15:0] ridx;
    logic        ru;
    logic [7:0]  rprio;
    logic [7:0]  ep;
    logic        eo;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid       = 1'b0;
    req_bits_index  = '0;
    req_bits_update = 1'b0;
    req_bits_prio   = '0;
    ctrl_wr_valid   = 1'b0;
    ctrl_wr_index   = '0;
    ctrl_wr_prio    = '0;
  endtask

  function automatic vec_t mk(input logic cv, input logic [15:0] cidx, input logic [7:0] cprio,
                              input logic rv, input logic [15:0] ridx, input logic ru,
                              input logic [7:0] rprio, input logic [7:0] ep, input logic eo);
    vec_t v;
    v.cv = cv; v.cidx = cidx; v.cprio = cprio;
    v.rv = rv; v.ridx = ridx; v.ru = ru; v.rprio = rprio;
    v.ep = ep; v.eo = eo;
    return v;
  endfunction

  // Drive one cycle of stimulus; the expected response goes to the scoreboard now.
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    ctrl_wr_valid   = v.cv;
    ctrl_wr_index   = v.cidx;
    ctrl_wr_prio    = v.cprio;
    req_valid       = v.rv;
    req_bits_index  = v.ridx;
    req_bits_update = v.ru;
    req_bits_prio   = v.rprio;
    if (v.rv) begin
      e.prio = v.ep;
      e.oob  = v.eo;
      e.tag  = tag;
      sbq.push_back(e);
    end
  endtask

  // Response monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (oob_err) check("oob_err_without_resp_valid", 32'(resp_valid), 32'd1);
      if (resp_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_resp_valid", 32'(resp_valid), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check($sformatf("resp_prio[tag %0d]", e.tag), 32'(resp_bits_prio), 32'(e.prio));
          check($sformatf("oob_err[tag %0d]", e.tag), 32'(oob_err), 32'(e.oob));
        end
      end
    end
  end

  // Counts cycles after reset release; init_done must rise exactly at cycle 1024.
  task automatic init_phase(input bit with_traffic);
    for (int k = 1; k <= 1024; k++) begin
      cyc();
      if (k == 2) check("resp_valid_quiet_in_init", 32'(resp_valid), 32'd0);
      if (k == 1023) check("init_done_before_1024", 32'(init_done), 32'd0);
      if (k == 1024) check("init_done_at_1024", 32'(init_done), 32'd1);
      if (with_traffic) begin
        if (k == 10) apply(mk(1'b1, 16'd4, 8'h66, 1'b1, 16'd3, 1'b1, 8'h55, 8'h00, 1'b0), 900);
        else if (k == 11) apply(mk(1'b0, 16'd0, 8'h00, 1'b1, 16'd2000, 1'b0, 8'h00, 8'h00, 1'b1), 901);
        else if (k == 12) idle_inputs();
      end
    end
  endtask

  task automatic drain();
    idle_inputs();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) cyc();
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    // columns: ctrl_v, ctrl_idx, ctrl_prio, req_v, req_idx, upd, req_prio, exp_prio, exp_oob
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd0,      0, 8'h00, 8'h00, 0)); // 0  cleared
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd511,    0, 8'h00, 8'h00, 0)); // 1
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd1023,   0, 8'h00, 8'h00, 0)); // 2
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd3,      0, 8'h00, 8'h00, 0)); // 3  INIT update dropped
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd4,      0, 8'h00, 8'h00, 0)); // 4  INIT ctrl dropped
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd5,      1, 8'h07, 8'h00, 0)); // 5  update 5<-7
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd5,      0, 8'h00, 8'h07, 0)); // 6  back-to-back
    vecs.push_back(mk(1, 16'd9,    8'h03, 1, 16'd9,      1, 8'h06, 8'h03, 0)); // 7  same idx
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd9,      0, 8'h00, 8'h06, 0)); // 8
    vecs.push_back(mk(1, 16'd2,    8'h04, 1, 16'd8,      1, 8'h01, 8'h00, 0)); // 9  diff idx
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd2,      0, 8'h00, 8'h04, 0)); // 10 pending fwd
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd8,      0, 8'h00, 8'h01, 0)); // 11
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd1024,   1, 8'h09, 8'h00, 1)); // 12 oob
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd0,      0, 8'h00, 8'h00, 0)); // 13 idx0 untouched
    vecs.push_back(mk(1, 16'd10,   8'hA1, 1, 16'd11,     1, 8'hB1, 8'h00, 0)); // 14 collision
    vecs.push_back(mk(1, 16'd12,   8'hA2, 1, 16'd13,     1, 8'hB2, 8'h00, 0)); // 15 collision while pending
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd10,     0, 8'h00, 8'hA1, 0)); // 16
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd11,     0, 8'h00, 8'hB1, 0)); // 17
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd12,     0, 8'h00, 8'hA2, 0)); // 18
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd13,     0, 8'h00, 8'hB2, 0)); // 19
    vecs.push_back(mk(1, 16'd1026, 8'h77, 1, 16'd2,      0, 8'h00, 8'h04, 0)); // 20 oob ctrl dropped
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd2,      0, 8'h00, 8'h04, 0)); // 21
    vecs.push_back(mk(1, 16'd20,   8'h33, 1, 16'd20,     0, 8'h00, 8'h33, 0)); // 22 ctrl then read
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd20,     0, 8'h00, 8'h33, 0)); // 23
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'hFFFF,   0, 8'h00, 8'h00, 1)); // 24 max idx
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd1023,   1, 8'hEE, 8'h00, 0)); // 25 top entry
    vecs.push_back(mk(0, 16'd0,    8'h00, 1, 16'd1023,   0, 8'h00, 8'hEE, 0)); // 26

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_resp_prio", 32'(resp_bits_prio), 32'd0);
    check("reset_init_done", 32'(init_done), 32'd0);
    check("reset_oob_err", 32'(oob_err), 32'd0);
    reset = 1'b0;

    init_phase(1'b1);

    foreach (vecs[i]) begin
      apply(vecs[i], i);
      cyc();
    end
    drain();

    // Reset while responses are in flight: only the first one may appear.
    apply(mk(0, 16'd0, 8'h00, 1, 16'd5, 0, 8'h00, 8'h07, 0), 950);
    cyc();
    req_bits_index = 16'd9;  // second request, its response is killed by reset
    cyc();
    req_bits_index = 16'd2;  // third request, killed as well
    cyc();
    reset = 1'b1;
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("resp_valid_in_reset", 32'(resp_valid), 32'd0);
      check("init_done_in_reset", 32'(init_done), 32'd0);
    end
    sbq.delete();
    reset = 1'b0;
    init_phase(1'b0);

    apply(mk(0, 16'd0, 8'h00, 1, 16'd5,  0, 8'h00, 8'h00, 0), 960);
    cyc();
    apply(mk(0, 16'd0, 8'h00, 1, 16'd9,  0, 8'h00, 8'h00, 0), 961);
    cyc();
    apply(mk(0, 16'd0, 8'h00, 1, 16'd20, 0, 8'h00, 8'h00, 0), 962);
    cyc();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
